// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
//  Module   : pll_lock_supervisor
//  Purpose  : Drives the PLL reset input and supervises the PLL locked output.
//             It holds the PLL in reset for a fixed time, waits for lock with
//             a timeout and retry, and qualifies lock as stable before it
//             releases the downstream system reset. It also detects loss of
//             lock while running and restarts the whole sequence.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    refclk        in   50 MHz reference clock, all logic on rising edge
//    rst           in   asynchronous active-high reset
//    pll_locked    in   PLL locked flag, asynchronous to refclk
//    pll_rst       out  PLL reset (registered)
//    sys_rst       out  active-high downstream system reset (registered)
//    lock_lost     out  one-cycle pulse when loss of lock is declared in RUN
//    state         out  00 PLL_RESET, 01 WAIT_LOCK, 10 STABILIZE, 11 RUN
//    timeout_count out  WAIT_LOCK timeouts, saturating at 255
//    loss_count    out  lock losses in RUN, saturating at 255
// ----------------------------------------------------------------------------
//  Build option
//    PLL_SUP_GLITCH_FILTER_EN : when defined, RUN tolerates short lock drops
//    and declares loss only after GLITCH_CYCLES consecutive unlocked cycles.
//    When undefined, a single unlocked cycle in RUN declares loss.
// ============================================================================
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int CNT_W               = 17
`ifdef PLL_SUP_GLITCH_FILTER_EN
    ,
    parameter int GLITCH_CYCLES       = 4
`endif
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       lock_lost,
    output logic [1:0] state,
    output logic [7:0] timeout_count,
    output logic [7:0] loss_count
);

    localparam logic [1:0] S_PLL_RESET = 2'b00;
    localparam logic [1:0] S_WAIT_LOCK = 2'b01;
    localparam logic [1:0] S_STABILIZE = 2'b10;
    localparam logic [1:0] S_RUN       = 2'b11;

    // Terminal counter values: a state is left in the cycle its counter
    // reads N-1, so the state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] C_RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ZERO    = '0;
    localparam logic [CNT_W-1:0] C_CNT_ONE     = CNT_W'(1);
    localparam logic [7:0]       C_COUNT_MAX   = 8'hFF;

`ifdef PLL_SUP_GLITCH_FILTER_EN
    localparam logic [CNT_W-1:0] C_GLITCH_LAST = CNT_W'(GLITCH_CYCLES - 1);
`endif

    logic             sync1_q;
    logic             locked_s_q;
    logic [1:0]       state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             pll_rst_q,    pll_rst_d;
    logic             sys_rst_q,    sys_rst_d;
    logic             lock_lost_q,  lock_lost_d;
    logic [7:0]       timeout_cnt_q, timeout_cnt_d;
    logic [7:0]       loss_cnt_q,   loss_cnt_d;
    logic             loss_w;
`ifdef PLL_SUP_GLITCH_FILTER_EN
    logic [CNT_W-1:0] glitch_q,     glitch_d;
`endif

    // ------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous locked flag.
    // ------------------------------------------------------------------
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= pll_locked;
            locked_s_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Loss-of-lock detection in RUN.
    // ------------------------------------------------------------------
`ifdef PLL_SUP_GLITCH_FILTER_EN
    // The glitch counter only runs in RUN; it counts consecutive unlocked
    // cycles and any locked cycle forgives the drop completely.
    always_comb begin
        glitch_d = C_CNT_ZERO;
        loss_w   = 1'b0;
        if (state_q == S_RUN && !locked_s_q) begin
            if (glitch_q == C_GLITCH_LAST) begin
                loss_w = 1'b1;
            end else begin
                glitch_d = glitch_q + C_CNT_ONE;
            end
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            glitch_q <= C_CNT_ZERO;
        end else begin
            glitch_q <= glitch_d;
        end
    end
`else
    always_comb begin
        loss_w = (state_q == S_RUN) && !locked_s_q;
    end
`endif

    // ------------------------------------------------------------------
    // Supervisor state machine and shared cycle counter.
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + C_CNT_ONE;
        lock_lost_d   = 1'b0;
        timeout_cnt_d = timeout_cnt_q;
        loss_cnt_d    = loss_cnt_q;

        case (state_q)
            S_PLL_RESET: begin
                if (cnt_q == C_RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = C_CNT_ZERO;
                end
            end
            S_WAIT_LOCK: begin
                // Lock takes priority over a timeout expiring in the same cycle.
                if (locked_s_q) begin
                    state_d = S_STABILIZE;
                    cnt_d   = C_CNT_ZERO;
                end else if (cnt_q == C_TIMEOUT_LAST) begin
                    state_d = S_PLL_RESET;
                    cnt_d   = C_CNT_ZERO;
                    if (timeout_cnt_q != C_COUNT_MAX) begin
                        timeout_cnt_d = timeout_cnt_q + 8'd1;
                    end
                end
            end
            S_STABILIZE: begin
                // A drop during qualification goes back to waiting with a
                // fresh timeout window; it is not counted as a timeout.
                if (!locked_s_q) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = C_CNT_ZERO;
                end else if (cnt_q == C_STABLE_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = C_CNT_ZERO;
                end
            end
            S_RUN: begin
                // RUN has no timed exit, so the counter is parked at zero
                // instead of free-running and wrapping.
                cnt_d = cnt_q;
                if (loss_w) begin
                    state_d     = S_PLL_RESET;
                    cnt_d       = C_CNT_ZERO;
                    lock_lost_d = 1'b1;
                    if (loss_cnt_q != C_COUNT_MAX) begin
                        loss_cnt_d = loss_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_PLL_RESET;
                cnt_d   = C_CNT_ZERO;
            end
        endcase

        // Reset outputs are decoded from the next state so that they change
        // on the same edge as the state register.
        pll_rst_d = (state_d == S_PLL_RESET);
        sys_rst_d = (state_d != S_RUN);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q       <= S_PLL_RESET;
            cnt_q         <= C_CNT_ZERO;
            pll_rst_q     <= 1'b1;
            sys_rst_q     <= 1'b1;
            lock_lost_q   <= 1'b0;
            timeout_cnt_q <= 8'd0;
            loss_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pll_rst_q     <= pll_rst_d;
            sys_rst_q     <= sys_rst_d;
            lock_lost_q   <= lock_lost_d;
            timeout_cnt_q <= timeout_cnt_d;
            loss_cnt_q    <= loss_cnt_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign sys_rst       = sys_rst_q;
    assign lock_lost     = lock_lost_q;
    assign state         = state_q;
    assign timeout_count = timeout_cnt_q;
    assign loss_count    = loss_cnt_q;

endmodule
`default_nettype wire
